// File: rtl/lbp_image_host_if.sv
// ----------------------------------------------------------------------------
// lbp_image_host_if
// Bundles every bus signal between the LBP image host and its environment:
//   image load stream  : img_valid, img_data  -> host ; img_ready <- host
//   gray read port     : gray_req, gray_addr  -> host ; gray_ready, gray_data <- host
//   lbp write port     : lbp_valid, lbp_addr, lbp_data, finish -> host
//   result dump stream : out_ready -> host ; out_valid, out_addr, out_data <- host
//   status             : done, protocol_err <- host
// The slave modport is the host's view; the master modport is the view of
// whoever drives the image, plays the LBP engine and drains the dump.
// ----------------------------------------------------------------------------
interface lbp_image_host_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8
);
    logic              img_valid;
    logic [DATA_W-1:0] img_data;
    logic              img_ready;

    logic [ADDR_W-1:0] gray_addr;
    logic              gray_req;
    logic              gray_ready;
    logic [DATA_W-1:0] gray_data;

    logic [ADDR_W-1:0] lbp_addr;
    logic              lbp_valid;
    logic [DATA_W-1:0] lbp_data;
    logic              finish;

    logic              out_valid;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    logic              done;
    logic              protocol_err;

    modport slave (
        input  img_valid, img_data, gray_addr, gray_req,
               lbp_addr, lbp_valid, lbp_data, finish, out_ready,
        output img_ready, gray_ready, gray_data,
               out_valid, out_addr, out_data, done, protocol_err
    );

    modport master (
        output img_valid, img_data, gray_addr, gray_req,
               lbp_addr, lbp_valid, lbp_data, finish, out_ready,
        input  img_ready, gray_ready, gray_data,
               out_valid, out_addr, out_data, done, protocol_err
    );
endinterface

// File: rtl/lbp_image_host.sv
// ----------------------------------------------------------------------------
// lbp_image_host
// Memory-side partner of an LBP engine. It loads a SIDE x SIDE gray image from
// a byte stream, serves zero-latency gray reads to the engine, captures the
// engine's LBP result writes, and after finish streams every result byte out
// in raster order with border pixels forced to zero.
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous, active-low; returns to LOAD, memories keep contents
//   bus    : lbp_image_host_if.slave (load stream, gray read port, lbp write
//            port, dump stream, done and sticky protocol_err)
// Addresses are {row, col}, each half of ADDR_W bits.
// ----------------------------------------------------------------------------
module lbp_image_host #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8,
    parameter int SIDE   = 128
) (
    input  logic               clk,
    input  logic               reset,
    lbp_image_host_if.slave    bus
);

    localparam int N_PIX  = SIDE * SIDE;
    localparam int CNT_W  = ADDR_W + 1;
    localparam int HALF_W = ADDR_W / 2;

    localparam logic [CNT_W-1:0]  LAST_PIX = CNT_W'(N_PIX - 1);
    localparam logic [HALF_W-1:0] EDGE_HI  = HALF_W'(SIDE - 1);

    typedef enum logic [1:0] {
        LOAD,
        SERVE,
        DUMP,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  load_cnt_q, load_cnt_d;
    logic [CNT_W-1:0]  dump_cnt_q, dump_cnt_d;
    logic              gray_ready_q, gray_ready_d;
    logic              protocol_err_q, protocol_err_d;

    logic [DATA_W-1:0] gray_mem [N_PIX];
    logic [DATA_W-1:0] res_mem  [N_PIX];

    logic              gray_we;
    logic              res_we;
    logic              img_ready_o;
    logic              out_valid_o;
    logic              done_o;
    logic [ADDR_W-1:0] out_addr_o;

    // A pixel lies on the border when its row or column is first or last.
    function automatic logic is_border(input logic [ADDR_W-1:0] a);
        logic [HALF_W-1:0] row;
        logic [HALF_W-1:0] col;
        row = a[ADDR_W-1:HALF_W];
        col = a[HALF_W-1:0];
        return (row == '0) || (row == EDGE_HI) || (col == '0) || (col == EDGE_HI);
    endfunction

    // Next-state, counters, error flag and handshake outputs. Counters are one
    // bit wider than the address so they stop at N_PIX instead of wrapping.
    always_comb begin
        state_d        = state_q;
        load_cnt_d     = load_cnt_q;
        dump_cnt_d     = dump_cnt_q;
        protocol_err_d = protocol_err_q;
        gray_we        = 1'b0;
        res_we         = 1'b0;
        img_ready_o    = 1'b0;
        out_valid_o    = 1'b0;
        done_o         = 1'b0;

        if ((state_q != SERVE) && (bus.gray_req || bus.lbp_valid)) begin
            protocol_err_d = 1'b1;
        end

        case (state_q)
            LOAD: begin
                img_ready_o = 1'b1;
                if (bus.img_valid) begin
                    gray_we    = 1'b1;
                    load_cnt_d = load_cnt_q + 1'b1;
                    if (load_cnt_q == LAST_PIX) begin
                        state_d = SERVE;
                    end
                end
            end
            SERVE: begin
                if (bus.lbp_valid) begin
                    if (is_border(bus.lbp_addr)) begin
                        protocol_err_d = 1'b1;
                    end else begin
                        res_we = 1'b1;
                    end
                end
                if (bus.finish) begin
                    state_d = DUMP;
                end
            end
            DUMP: begin
                out_valid_o = 1'b1;
                if (bus.out_ready) begin
                    dump_cnt_d = dump_cnt_q + 1'b1;
                    if (dump_cnt_q == LAST_PIX) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                done_o = 1'b1;
            end
            default: begin
                state_d = LOAD;
            end
        endcase

        gray_ready_d = (state_d == SERVE);
    end

    // State and control registers; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= LOAD;
            load_cnt_q     <= '0;
            dump_cnt_q     <= '0;
            gray_ready_q   <= 1'b0;
            protocol_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            load_cnt_q     <= load_cnt_d;
            dump_cnt_q     <= dump_cnt_d;
            gray_ready_q   <= gray_ready_d;
            protocol_err_q <= protocol_err_d;
        end
    end

    // Image and result memories are never cleared; writes are suppressed in
    // the reset cycle so an abandoned transfer cannot land one extra byte.
    always_ff @(posedge clk) begin
        if (reset && gray_we) begin
            gray_mem[load_cnt_q[ADDR_W-1:0]] <= bus.img_data;
        end
        if (reset && res_we) begin
            res_mem[bus.lbp_addr] <= bus.lbp_data;
        end
    end

    assign out_addr_o     = dump_cnt_q[ADDR_W-1:0];

    assign bus.img_ready    = img_ready_o;
    assign bus.gray_ready   = gray_ready_q;
    assign bus.gray_data    = ((state_q == SERVE) && bus.gray_req) ? gray_mem[bus.gray_addr] : '0;
    assign bus.out_valid    = out_valid_o;
    assign bus.out_addr     = out_addr_o;
    assign bus.out_data     = is_border(out_addr_o) ? '0 : res_mem[out_addr_o];
    assign bus.done         = done_o;
    assign bus.protocol_err = protocol_err_q;

endmodule
